// File: rtl/wb_led_walker_pkg.sv
// -----------------------------------------------------------------------------
// wb_led_walker_pkg
// Shared definitions for the wishbone LED walker: register addresses, CTRL
// register bit positions, walk mode encodings and bounce direction.
// -----------------------------------------------------------------------------
package wb_led_walker_pkg;

    // Register map (i_addr values)
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STEP   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_LED    = 2'd3;

    // CTRL register bit positions
    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_MODE    = 1;
    localparam int unsigned CTRL_STOP    = 2;
    localparam int unsigned CTRL_REP_LSB = 8;
    localparam int unsigned CTRL_REP_MSB = 15;

    // Walk mode as written to CTRL[MODE]
    typedef enum logic {
        MODE_BOUNCE = 1'b0,
        MODE_WRAP   = 1'b1
    } mode_t;

    // Travel direction inside a bounce pass
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/wb_led_walker_divider.sv
// -----------------------------------------------------------------------------
// wb_led_walker_divider
// Step divider: counts 0 .. max(i_step,1)-1 while enabled and flags the
// terminal count on o_strobe.
// Ports:
//   i_clk     clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_en      count enable (walk in progress)
//   i_clr     synchronous clear of the count
//   i_step    clocks per strobe; 0 is treated as 1
//   o_strobe  combinational, high in the last clock of each step
// -----------------------------------------------------------------------------
module wb_led_walker_divider (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic [31:0] i_step,
    output logic        o_strobe
);

    logic [31:0] r_count;
    logic [31:0] w_limit;

    assign w_limit = (i_step == '0) ? '0 : i_step - 32'd1;

    // >= rather than == so that shrinking the step below the current count
    // fires on the very next cycle instead of waiting for a 32-bit wrap.
    assign o_strobe = i_en && (r_count >= w_limit);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_strobe ? '0 : r_count + 32'd1;
        end
    end

endmodule

// File: rtl/wb_led_walker.sv
// -----------------------------------------------------------------------------
// wb_led_walker
// Wishbone-controlled walking LED: a single lit LED moves across NLEDS outputs
// in bounce or wrap mode, one position per STEP clocks, for REPEAT passes
// (0 = until stopped).
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_cyc, i_stb, i_we        wishbone cycle / strobe / write enable
//   i_addr, i_data            register select, write data
//   o_stall, o_ack, o_data    wishbone stall, ack (one cycle after accept),
//                             registered read data (0 for writes)
//   o_led                     one-hot LED drive while busy, zero while idle
//   o_busy                    walk in progress
//   o_int                     one-cycle pulse when a finite walk completes
// -----------------------------------------------------------------------------
module wb_led_walker #(
    parameter int unsigned NLEDS    = 8,
    parameter logic [31:0] DEF_STEP = 32'd50_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cyc,
    input  logic             i_stb,
    input  logic             i_we,
    input  logic [1:0]       i_addr,
    input  logic [31:0]      i_data,
    output logic             o_stall,
    output logic             o_ack,
    output logic [31:0]      o_data,
    output logic [NLEDS-1:0] o_led,
    output logic             o_busy,
    output logic             o_int
);

    import wb_led_walker_pkg::*;

    localparam int unsigned      PW      = $clog2(NLEDS);
    localparam logic [PW-1:0]    LAST    = PW'(NLEDS - 1);
    localparam logic [NLEDS-1:0] LED_ONE = NLEDS'(1);

    logic             r_busy;
    mode_t            r_mode;
    dir_t             r_dir;
    logic [PW-1:0]    r_pos;
    logic [7:0]       r_passes;
    logic [NLEDS-1:0] r_led;
    logic             r_int;
    logic [31:0]      r_step;
    logic             r_ack;
    logic [31:0]      r_data;

    logic             w_acc;
    logic             w_ctrl_wr;
    logic             w_start;
    logic             w_stop;
    logic             w_strobe;
    logic             w_clr;
    logic [PW-1:0]    w_pos_nxt;
    dir_t             w_dir_nxt;
    logic             w_pass_end;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // i_cyc is intentionally not part of acceptance, so dropping it can never
    // cancel an ack that is already in flight.
    assign w_unused = i_cyc;

    assign w_ctrl_wr = i_we && (i_addr == ADDR_CTRL);
    assign o_stall   = i_stb && w_ctrl_wr && i_data[CTRL_START]
                       && !i_data[CTRL_STOP] && r_busy;
    assign w_acc     = i_stb && !o_stall;
    assign w_start   = w_acc && w_ctrl_wr && i_data[CTRL_START] && !i_data[CTRL_STOP];
    assign w_stop    = w_acc && w_ctrl_wr && i_data[CTRL_STOP];
    assign w_clr     = !r_busy || w_start;

    wb_led_walker_divider u_divider (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_en     (r_busy),
        .i_clr    (w_clr),
        .i_step   (r_step),
        .o_strobe (w_strobe)
    );

    // Next position; w_pass_end marks the strobe that leaves the last
    // position of a pass (top in wrap, bottom on the way down in bounce).
    always_comb begin
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir;
        w_pass_end = 1'b0;
        if (r_mode == MODE_WRAP) begin
            if (r_pos == LAST) begin
                w_pos_nxt  = '0;
                w_pass_end = 1'b1;
            end else begin
                w_pos_nxt = r_pos + PW'(1);
            end
        end else if (r_dir == DIR_UP) begin
            if (r_pos == LAST) begin
                w_pos_nxt = LAST - PW'(1);
                w_dir_nxt = DIR_DOWN;
            end else begin
                w_pos_nxt = r_pos + PW'(1);
            end
        end else begin
            if (r_pos == '0) begin
                // next bounce pass starts at 1: position 0 is not shown twice
                w_pos_nxt  = PW'(1);
                w_dir_nxt  = DIR_UP;
                w_pass_end = 1'b1;
            end else begin
                w_pos_nxt = r_pos - PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy   <= 1'b0;
            r_mode   <= MODE_BOUNCE;
            r_dir    <= DIR_UP;
            r_pos    <= '0;
            r_passes <= '0;
            r_led    <= '0;
            r_int    <= 1'b0;
            r_step   <= DEF_STEP;
        end else begin
            r_int <= 1'b0;
            if (w_acc && i_we && (i_addr == ADDR_STEP)) begin
                r_step <= i_data;
            end
            if (w_stop) begin
                if (r_busy) begin
                    r_busy   <= 1'b0;
                    r_led    <= '0;
                    r_pos    <= '0;
                    r_dir    <= DIR_UP;
                    r_passes <= '0;
                end
            end else if (w_start) begin
                r_busy   <= 1'b1;
                r_pos    <= '0;
                r_dir    <= DIR_UP;
                r_led    <= LED_ONE;
                r_mode   <= mode_t'(i_data[CTRL_MODE]);
                r_passes <= i_data[CTRL_REP_MSB:CTRL_REP_LSB];
            end else if (r_busy && w_strobe) begin
                if (w_pass_end && (r_passes == 8'd1)) begin
                    r_busy   <= 1'b0;
                    r_led    <= '0;
                    r_int    <= 1'b1;
                    r_pos    <= '0;
                    r_dir    <= DIR_UP;
                    r_passes <= '0;
                end else begin
                    r_pos <= w_pos_nxt;
                    r_dir <= w_dir_nxt;
                    r_led <= LED_ONE << w_pos_nxt;
                    if (w_pass_end && (r_passes != 8'd0)) begin
                        r_passes <= r_passes - 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_addr)
            ADDR_STEP:   w_rdata = r_step;
            ADDR_STATUS: begin
                w_rdata[0]       = r_busy;
                w_rdata[1]       = r_mode;
                w_rdata[8 +: PW] = r_pos;
                w_rdata[23:16]   = r_passes;
            end
            ADDR_LED:    w_rdata[NLEDS-1:0] = r_led;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ack  <= 1'b0;
            r_data <= '0;
        end else begin
            r_ack  <= w_acc;
            r_data <= (w_acc && !i_we) ? w_rdata : '0;
        end
    end

    assign o_ack  = r_ack;
    assign o_data = r_data;
    assign o_led  = r_led;
    assign o_busy = r_busy;
    assign o_int  = r_int;

endmodule

// File: doc/wb_led_walker.md
WB_LED_WALKER -- requirements
Module: wb_led_walker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NLEDS, 8, LED count, legal range 2..32.
- DEF_STEP, 50_000_000, reset value of STEP (clocks per LED step).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, sole clock, rising edge.
- i_reset, in, 1, asynchronous, active-high reset.
- i_cyc, in, 1, wishbone cycle.
- i_stb, in, 1, wishbone strobe.
- i_we, in, 1, write enable.
- i_addr, in, 2, register select.
- i_data, in, 32, write data.
- o_stall, out, 1, wishbone stall.
- o_ack, out, 1, wishbone ack.
- o_data, out, 32, read data.
- o_led, out, NLEDS, LED drive.
- o_busy, out, 1, walk in progress.
- o_int, out, 1, one-cycle pulse when a finite walk completes.
REQ-003 Clocking and reset SHALL be: one clock (i_clk); reset i_reset is asynchronous and active-high.

Function
REQ-004 Register map SHALL be:
- 0 CTRL (write): bit0 START, bit1 MODE (0 bounce, 1 wrap), bit2 STOP, bits[15:8] REPEAT.
- 1 STEP (read/write): [31:0].
- 2 STATUS (read): bit0 busy, bit1 mode, [12:8] position, [23:16] passes remaining.
- 3 LED (read): o_led zero-extended.
REQ-005 A request SHALL be accepted when i_stb && !o_stall; o_ack SHALL be high exactly one cycle later; o_data SHALL be registered and valid in the ack cycle; o_data SHALL be 0 for writes.
REQ-006 o_stall SHALL be high only for a CTRL write with START=1, STOP=0 while busy; all other requests SHALL never stall.
REQ-007 An accepted START (idle) SHALL, on the next edge:
- set busy;
- position 0 with o_led = 1;
- clear the step counter;
- latch MODE;
- load passes remaining = REPEAT.
REQ-008 Step counter SHALL count 0..max(STEP,1)-1 while busy; strobe = count reached; a STEP write of 0 SHALL behave as 1.
REQ-009 A STEP write while busy SHALL apply immediately; if counter >= new STEP-1, strobe SHALL fire on the next cycle.
REQ-010 Bounce mode: positions SHALL be 0,1..NLEDS-1,NLEDS-2..0 (2*NLEDS-1 LED states per pass); a new pass SHALL start at 1 going up (0 not repeated).
REQ-011 Wrap mode: positions SHALL be 0..NLEDS-1 per pass; the next pass SHALL start at 0.
REQ-012 On strobe at the last position of a pass:
- REPEAT≠0 and passes remaining==1: clear busy, o_led=0, pulse o_int, position 0.
- Otherwise: decrement (if nonzero) and continue.
REQ-013 REPEAT=0 SHALL mean run until STOP; passes remaining SHALL stay 0.
REQ-014 STOP (with or without START) SHALL on the next edge clear busy and o_led with no o_int; STOP while idle SHALL be a no-op.
REQ-015 START+STOP in one write SHALL act as STOP.
REQ-016 o_led SHALL be one-hot at the current position while busy and all-zero while idle; o_busy SHALL equal busy.
REQ-017 i_cyc low SHALL not abort an in-flight ack.

Reset
REQ-018 i_reset SHALL asynchronously force:
- o_ack=0, o_int=0, o_led=0, o_busy=0, o_data=0;
- position=0, counter=0, passes remaining=0, MODE=0, STEP=DEF_STEP.
REQ-019 Reset mid-walk SHALL abandon the walk with no o_int; the first accepted request after deassertion SHALL behave normally.

Structure
REQ-020 A shared package SHALL hold the register addresses (CTRL, STEP, STATUS, LED), CTRL bit positions, and the MODE encodings.
REQ-021 The step divider SHALL be a sub-module, wb_led_walker_divider (inputs: clock, reset, enable, clear, step value; output: strobe).
REQ-022 Position width SHALL be $clog2(NLEDS), with no out-of-range position reachable.

Verification (NLEDS=8, STEP=4)
REQ-023 Bench SHALL cover, with scoreboard checking of the ack-per-accepted-request rule:
- CTRL=0x0101 (bounce, REPEAT=1) -> o_led 0x01,0x02..0x80..0x01 (15 states, 4 clocks each); then o_led=0, one o_int, busy low.
- CTRL=0x0203 (wrap, REPEAT=2) -> 0x01..0x80 twice; STATUS[23:16] reads 2 then 1; one o_int after 64 clocks.
- CTRL=0x0001 (REPEAT=0) running; CTRL write START while busy -> o_stall held; CTRL=0x0004 -> busy clears next cycle, o_led=0, no o_int, stall released.
- STEP=0 then START -> LED advances every clock; STEP=2 written mid-walk with counter=3 -> strobe next cycle, then every 2.
- i_reset pulsed mid-walk at position 5 -> o_led=0, busy=0, STEP reads DEF_STEP; new START walks from 0x01.
- Back-to-back reads of STATUS, LED, STEP with no stall -> ack each following cycle with correct data.
